// File: rtl/row_cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | row_cache_pkg                                                        |
// | Shared FSM state type and default sizing for the row-buffer cache.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package row_cache_pkg;

    localparam int c_DEF_ROW_W   = 17;
    localparam int c_DEF_ENTRIES = 32;
    localparam int c_DEF_CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOOKUP     = 3'd1,
        ST_WRITEBACK  = 3'd2,
        ST_FILL       = 3'd3,
        ST_RESP       = 3'd4,
        ST_FLUSH_SCAN = 3'd5,
        ST_FLUSH_WB   = 3'd6
    } row_cache_state_t;

endpackage
`default_nettype wire

// File: rtl/row_cache_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | row_cache_match                                                      |
// | Parallel row compare with lowest-index priority for hit and free slot|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module row_cache_match
    import row_cache_pkg::*;
#(
    parameter int ROW_W   = c_DEF_ROW_W,
    parameter int ENTRIES = c_DEF_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] i_valid,
    input  logic [ROW_W-1:0]   i_rows [ENTRIES],
    input  logic [ROW_W-1:0]   i_row,
    output logic               o_hit,
    output logic [IDX_W-1:0]   o_hit_idx,
    output logic               o_any_invalid,
    output logic [IDX_W-1:0]   o_first_invalid_idx
);

    // Scanning downward lets the lowest matching index win.
    always_comb begin
        o_hit               = 1'b0;
        o_hit_idx           = '0;
        o_any_invalid       = 1'b0;
        o_first_invalid_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_rows[i] == i_row)) begin
                o_hit     = 1'b1;
                o_hit_idx = IDX_W'(i);
            end
            if (!i_valid[i]) begin
                o_any_invalid       = 1'b1;
                o_first_invalid_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/row_cache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | row_cache_ctrl                                                       |
// | Row-buffer cache controller: hit/miss, victim writeback, fill, flush.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module row_cache_ctrl
    import row_cache_pkg::*;
#(
    parameter int ROW_W   = c_DEF_ROW_W,
    parameter int ENTRIES = c_DEF_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int CNT_W   = c_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [ROW_W-1:0] req_row,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [IDX_W-1:0] resp_idx,
    output logic             hold,
    output logic             mem_req_valid,
    output logic             mem_req_wr,
    output logic [ROW_W-1:0] mem_req_row,
    input  logic             mem_ack,
    input  logic             flush,
    output logic             flush_done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [ROW_W-1:0] rowaddr;
    } entry_t;

    row_cache_state_t state_q, state_d;
    entry_t           entry_q [ENTRIES];
    entry_t           entry_d [ENTRIES];
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] scan_q, scan_d;
    logic [IDX_W-1:0] resp_idx_q, resp_idx_d;
    logic             resp_hit_q, resp_hit_d;
    logic             victim_rr_q, victim_rr_d;
    logic             wr_q, wr_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             flush_done_q, flush_done_d;

    logic [ENTRIES-1:0] w_valid;
    logic [ROW_W-1:0]   w_rows [ENTRIES];
    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_any_invalid;
    logic [IDX_W-1:0]   w_first_invalid_idx;
    logic [IDX_W-1:0]   w_victim;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_unpack
        assign w_valid[gi] = entry_q[gi].valid;
        assign w_rows[gi]  = entry_q[gi].rowaddr;
    end

    row_cache_match #(
        .ROW_W   (ROW_W),
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_match (
        .i_valid             (w_valid),
        .i_rows              (w_rows),
        .i_row               (row_q),
        .o_hit               (w_hit),
        .o_hit_idx           (w_hit_idx),
        .o_any_invalid       (w_any_invalid),
        .o_first_invalid_idx (w_first_invalid_idx)
    );

    assign w_victim = w_any_invalid ? w_first_invalid_idx : rr_ptr_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        rr_ptr_d     = rr_ptr_q;
        scan_d       = scan_q;
        resp_idx_d   = resp_idx_q;
        resp_hit_d   = resp_hit_q;
        victim_rr_d  = victim_rr_q;
        wr_d         = wr_q;
        row_d        = row_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        flush_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    scan_d  = '0;
                    state_d = ST_FLUSH_SCAN;
                end else if (req_valid) begin
                    wr_d    = req_wr;
                    row_d   = req_row;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    hit_cnt_d  = sat_inc(hit_cnt_q);
                    resp_hit_d = 1'b1;
                    resp_idx_d = w_hit_idx;
                    if (wr_q) begin
                        entry_d[w_hit_idx].dirty = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    miss_cnt_d  = sat_inc(miss_cnt_q);
                    resp_hit_d  = 1'b0;
                    resp_idx_d  = w_victim;
                    victim_rr_d = !w_any_invalid;
                    if (entry_q[w_victim].valid && entry_q[w_victim].dirty) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    entry_d[resp_idx_q] = '{valid: 1'b1, dirty: wr_q, rowaddr: row_q};
                    // Power-of-two depth makes the natural overflow the wrap.
                    if (victim_rr_q) begin
                        rr_ptr_d = rr_ptr_q + 1'b1;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_FLUSH_SCAN: begin
                if (entry_q[scan_q].valid && entry_q[scan_q].dirty) begin
                    state_d = ST_FLUSH_WB;
                end else if (&scan_q) begin
                    flush_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            ST_FLUSH_WB: begin
                if (mem_ack) begin
                    entry_d[scan_q].dirty = 1'b0;
                    if (&scan_q) begin
                        flush_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        scan_d  = scan_q + 1'b1;
                        state_d = ST_FLUSH_SCAN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
            rr_ptr_q     <= '0;
            scan_q       <= '0;
            resp_idx_q   <= '0;
            resp_hit_q   <= 1'b0;
            victim_rr_q  <= 1'b0;
            wr_q         <= 1'b0;
            row_q        <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            flush_done_q <= 1'b0;
        end else begin
            entry_q      <= entry_d;
            rr_ptr_q     <= rr_ptr_d;
            scan_q       <= scan_d;
            resp_idx_q   <= resp_idx_d;
            resp_hit_q   <= resp_hit_d;
            victim_rr_q  <= victim_rr_d;
            wr_q         <= wr_d;
            row_q        <= row_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Memory request is decoded straight from state so reset drops it asynchronously.
    always_comb begin
        mem_req_row = '0;
        case (state_q)
            ST_WRITEBACK: mem_req_row = entry_q[resp_idx_q].rowaddr;
            ST_FILL:      mem_req_row = row_q;
            ST_FLUSH_WB:  mem_req_row = entry_q[scan_q].rowaddr;
            default:      mem_req_row = '0;
        endcase
    end

    assign mem_req_valid = (state_q == ST_WRITEBACK) || (state_q == ST_FILL) ||
                           (state_q == ST_FLUSH_WB);
    assign mem_req_wr    = (state_q == ST_WRITEBACK) || (state_q == ST_FLUSH_WB);
    assign hold          = mem_req_valid;
    assign req_ready     = (state_q == ST_IDLE) && !flush;
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_hit      = resp_valid && resp_hit_q;
    assign resp_idx      = resp_valid ? resp_idx_q : '0;
    assign flush_done    = flush_done_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_row_cache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_row_cache_ctrl                                                    |
// | Scoreboard bench: reference cache model, randomized traffic, flush.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_row_cache_ctrl;

    localparam int ROW_W   = 17;
    localparam int ENTRIES = 32;
    localparam int IDX_W   = 5;
    localparam int CNT_W   = 16;
    localparam int SAT_W   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_wr = 1'b0;
    logic [ROW_W-1:0] req_row = '0;
    logic             mem_ack = 1'b0;
    logic             flush = 1'b0;

    logic             req_ready, resp_valid, resp_hit, hold;
    logic [IDX_W-1:0] resp_idx;
    logic             mem_req_valid, mem_req_wr, flush_done;
    logic [ROW_W-1:0] mem_req_row;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    logic             s_req_ready, s_resp_valid, s_resp_hit, s_hold;
    logic [IDX_W-1:0] s_resp_idx;
    logic             s_mem_req_valid, s_mem_req_wr, s_flush_done;
    logic [ROW_W-1:0] s_mem_req_row;
    logic [SAT_W-1:0] s_hit_cnt, s_miss_cnt;

    row_cache_ctrl #(.ROW_W(ROW_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_row(req_row), .resp_valid(resp_valid),
        .resp_hit(resp_hit), .resp_idx(resp_idx), .hold(hold),
        .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr),
        .mem_req_row(mem_req_row), .mem_ack(mem_ack), .flush(flush),
        .flush_done(flush_done), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Identical instance with 2-bit counters sees the same traffic.
    row_cache_ctrl #(.ROW_W(ROW_W), .ENTRIES(ENTRIES), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_wr(req_wr), .req_row(req_row), .resp_valid(s_resp_valid),
        .resp_hit(s_resp_hit), .resp_idx(s_resp_idx), .hold(s_hold),
        .mem_req_valid(s_mem_req_valid), .mem_req_wr(s_mem_req_wr),
        .mem_req_row(s_mem_req_row), .mem_ack(mem_ack), .flush(flush),
        .flush_done(s_flush_done), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hit;
        int idx;
        int hits;
        int misses;
        int exp_cyc;
    } resp_t;

    typedef struct {
        bit wr;
        int row;
    } mem_t;

    resp_t resp_q[$];
    mem_t  mem_q[$];

    bit m_valid [ENTRIES];
    bit m_dirty [ENTRIES];
    int m_row   [ENTRIES];
    int m_rr;
    int m_hits;
    int m_misses;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    bit flush_pending = 1'b0;
    int flush_seen = 0;
    int ready_leak = 0;
    bit ack_en = 1'b1;
    int ack_wait = 3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int cap(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_row[i]   = 0;
        end
        m_rr     = 0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_request(input int row, input bit wr, input int acc_cyc);
        resp_t r;
        mem_t  m;
        int    idx;
        int    v;
        idx = -1;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (m_valid[i] && m_row[i] == row) idx = i;
        if (idx >= 0) begin
            m_hits++;
            if (wr) m_dirty[idx] = 1'b1;
            r.hit = 1'b1;
            r.idx = idx;
            r.exp_cyc = acc_cyc + 2;
        end else begin
            m_misses++;
            v = -1;
            for (int i = ENTRIES - 1; i >= 0; i--)
                if (!m_valid[i]) v = i;
            if (v < 0) begin
                v = m_rr;
                m_rr = (m_rr + 1) % ENTRIES;
            end
            if (m_valid[v] && m_dirty[v]) begin
                m.wr = 1'b1; m.row = m_row[v]; mem_q.push_back(m);
            end
            m.wr = 1'b0; m.row = row; mem_q.push_back(m);
            m_valid[v] = 1'b1;
            m_dirty[v] = wr;
            m_row[v]   = row;
            r.hit = 1'b0;
            r.idx = v;
            r.exp_cyc = -1;
        end
        r.hits = m_hits;
        r.misses = m_misses;
        resp_q.push_back(r);
    endtask

    task automatic model_flush();
        mem_t m;
        for (int i = 0; i < ENTRIES; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                m.wr = 1'b1; m.row = m_row[i]; mem_q.push_back(m);
                m_dirty[i] = 1'b0;
            end
        end
    endtask

    // Memory model: acknowledges after a random 0..3 cycle delay.
    always @(posedge clk) begin
        #1;
        mem_ack = 1'b0;
        if (rst && ack_en && mem_req_valid) begin
            if (ack_wait == 0) begin
                mem_ack = 1'b1;
                ack_wait = $urandom_range(0, 3);
            end else begin
                ack_wait--;
            end
        end
    end

    always @(negedge clk) begin
        resp_t e;
        mem_t  m;
        if (rst) begin
            if (mem_req_valid && mem_ack) begin
                if (mem_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL mem_unexpected actual wr=%0b row=%0h required none", mem_req_wr, mem_req_row);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_wr", 64'(mem_req_wr), 64'(m.wr));
                    check("mem_row", 64'(mem_req_row), 64'(m.row));
                end
                last_ack_cyc = cyc;
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL resp_unexpected actual idx=%0d required none", resp_idx);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_hit", 64'(resp_hit), 64'(e.hit));
                    check("resp_idx", 64'(resp_idx), 64'(e.idx));
                    check("resp_latency", 64'(cyc), 64'(e.hit ? e.exp_cyc : last_ack_cyc + 1));
                    check("hit_cnt", 64'(hit_cnt), 64'(cap(e.hits, CNT_W)));
                    check("miss_cnt", 64'(miss_cnt), 64'(cap(e.misses, CNT_W)));
                    check("sat_hit_cnt", 64'(s_hit_cnt), 64'(cap(e.hits, SAT_W)));
                    check("sat_miss_cnt", 64'(s_miss_cnt), 64'(cap(e.misses, SAT_W)));
                end
            end
            if (flush_pending && !flush_done && req_ready) ready_leak++;
            if (flush_done) begin
                checks++;
                if (!flush_pending) begin
                    failures++;
                    $display("FAIL flush_done_unexpected actual=1 required=0");
                end else begin
                    check("flush_wb_remaining", 64'(mem_q.size()), 64'd0);
                    flush_pending = 1'b0;
                    flush_seen++;
                end
            end
        end
    end

    task automatic clear_queues();
        resp_q.delete();
        mem_q.delete();
        flush_pending = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || mem_q.size() != 0 || flush_pending) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++; failures++;
            $display("FAIL idle_timeout actual=pending required=drained");
            clear_queues();
        end
    endtask

    task automatic issue_req(input int row, input bit wr, output bit ok);
        int n;
        ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_wr    = wr;
        req_row   = ROW_W'(row);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL req_accept_timeout actual=0 required=1");
        end else begin
            model_request(row, wr, cyc);
            ok = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_req(input int row, input bit wr);
        bit ok;
        issue_req(row, wr, ok);
        if (ok) wait_idle();
    endtask

    task automatic do_flush();
        int seen0;
        seen0 = flush_seen;
        ready_leak = 0;
        @(posedge clk); #1;
        flush = 1'b1;
        model_flush();
        flush_pending = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_idle();
        check("flush_done_count", 64'(flush_seen - seen0), 64'd1);
        check("flush_ready_low", 64'(ready_leak), 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_queues();
        model_reset();
        ack_wait = 3;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        int n;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_hold", 64'(hold), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);

        // Cold miss then hit on the same row.
        do_req(32'h5, 1'b0);
        do_req(32'h5, 1'b0);

        // Fill every entry dirty, then force a round-robin eviction with writeback.
        apply_reset();
        for (int r = 0; r < ENTRIES; r++) do_req(r, 1'b1);
        do_req(100, 1'b1);

        // Clean everything, dirty two rows, flush exactly those back.
        do_flush();
        do_req(3, 1'b1);
        do_req(7, 1'b1);
        do_flush();
        do_req(3, 1'b0);

        // Reset while a fill is outstanding.
        ack_en = 1'b0;
        issue_req(200, 1'b0, ok);
        n = 0;
        @(negedge clk);
        while (!(mem_req_valid && !mem_req_wr) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("fill_reached", 64'(mem_req_valid && !mem_req_wr), 64'd1);
        rst = 1'b0;
        #1;
        check("midfill_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("midfill_hold", 64'(hold), 64'd0);
        clear_queues();
        model_reset();
        ack_en = 1'b1;
        ack_wait = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_hit_cnt", 64'(hit_cnt), 64'd0);
        check("post_rst_miss_cnt", 64'(miss_cnt), 64'd0);
        do_req(3, 1'b0);

        // Saturation of the narrow counters.
        apply_reset();
        for (int k = 0; k < 5; k++) do_req(50, 1'b0);
        check("sat_hit_cnt_stuck", 64'(s_hit_cnt), 64'd3);

        // Randomized traffic over a row range slightly larger than the cache.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_flush();
            end else begin
                do_req($urandom_range(0, 47), 1'($urandom_range(0, 1)));
            end
        end

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
